// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the 32-bit ALU with a sequential multiplier.
// Holds operands stable, times multiplies, and returns results over valid/ready.
module alu_seq_ctrl #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 33,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [2:0]       req_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             mult_start,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_op,
    output logic             busy
);

    localparam logic [2:0]       OP_MUL   = 3'b010;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MSTART,
        S_MWAIT,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_capture;

    // Ready is the only combinational output; it must drop while rst is held.
    assign req_ready = (r_state == S_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = (req_op == OP_MUL) ? S_MSTART : S_EXEC;
                end
            end
            S_EXEC: begin
                w_capture    = 1'b1;
                w_next_state = S_RESP;
            end
            S_MSTART: begin
                w_next_state = S_MWAIT;
            end
            S_MWAIT: begin
                if (r_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Multiply wait counter: loaded in MSTART so MWAIT spans exactly MULT_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_MSTART) begin
            r_cnt <= CNT_LOAD;
        end else if ((r_state == S_MWAIT) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= 3'b000;
            rsp_result <= '0;
            rsp_op     <= 3'b000;
            mult_start <= 1'b0;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (w_accept) begin
                alu_a  <= req_a;
                alu_b  <= req_b;
                alu_op <= req_op;
            end
            if (w_capture) begin
                rsp_result <= alu_result;
                rsp_op     <= alu_op;
            end
            // Registered decodes of the next state keep these aligned with r_state.
            mult_start <= (w_next_state == S_MSTART);
            rsp_valid  <= (w_next_state == S_RESP);
            busy       <= (w_next_state != S_IDLE);
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed testbench for alu_seq_ctrl with a behavioural ALU/multiplier model.
module tb_alu_seq_ctrl;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned MC    = 33;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b111;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_op;
    logic             mult_start;
    logic [WIDTH-1:0] alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [2:0]       rsp_op;
    logic             busy;

    int n_chk  = 0;
    int n_pass = 0;

    alu_seq_ctrl #(.WIDTH(WIDTH), .MULT_CYCLES(MC), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .mult_start (mult_start),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_op     (rsp_op),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Multiplier model: product is garbage until MC cycles after the start pulse.
    logic [8:0]       mcnt = 9'd0;
    logic [WIDTH-1:0] product;
    assign product = alu_a * alu_b;

    always_ff @(posedge clk) begin
        if (mult_start) begin
            mcnt <= 9'd1;
        end else if ((mcnt != 9'd0) && (mcnt < 9'd300)) begin
            mcnt <= mcnt + 9'd1;
        end
    end

    always_comb begin
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_MUL:  alu_result = (mcnt >= 9'(MC)) ? product : 32'hDEAD_BEEF;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_SLT:  alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            default: alu_result = alu_a | alu_b;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, required %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Issues one op in the current cycle (T) and measures latency to rsp_valid.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input int exp_lat, input logic [31:0] exp_res);
        int lat;
        int ms_cnt;
        int ms_at;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_valid = 1'b1;
        check({tag, " ready_at_T"}, 32'(req_ready), 32'd1);
        step;
        req_valid = 1'b0;
        lat    = 1;
        ms_cnt = 0;
        ms_at  = -1;
        while (!rsp_valid && lat < 300) begin
            if (mult_start) begin
                ms_cnt++;
                ms_at = lat;
            end
            step;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " result"}, rsp_result, exp_res);
        check({tag, " rsp_op"}, 32'(rsp_op), 32'(op));
        check({tag, " busy_in_resp"}, 32'(busy), 32'd1);
        if (op == OP_MUL) begin
            check({tag, " mult_start_count"}, 32'(ms_cnt), 32'd1);
            check({tag, " mult_start_cycle"}, 32'(ms_at), 32'd1);
        end
        step;
        check({tag, " rsp_valid_dropped"}, 32'(rsp_valid), 32'd0);
        check({tag, " ready_again"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int wait_cyc;
        logic seen;
        logic [31:0] va [2];
        logic [31:0] vb [2];
        logic [2:0]  vo [2];
        logic [31:0] rr [2];
        int rc [2];
        int iss;
        int nr;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = 3'b000;
        rsp_ready = 1'b1;

        // Reset then idle
        repeat (3) step;
        check("rst ready_low", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst ready", 32'(req_ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst mult_start", 32'(mult_start), 32'd0);
        check("rst alu_a", alu_a, 32'd0);
        check("rst alu_b", alu_b, 32'd0);
        check("rst alu_op", 32'(alu_op), 32'd0);
        check("rst rsp_result", rsp_result, 32'd0);
        check("rst rsp_op", 32'(rsp_op), 32'd0);
        step;

        // Add and multiply with full latency
        run_op("add", 32'd7, 32'd5, OP_ADD, 2, 32'd12);
        run_op("mul", 32'd1234, 32'd5678, OP_MUL, 2 + MC, 32'd7006652);
        check("mul alu_a_held", alu_a, 32'd1234);

        // Backpressure: sub held in RESP while a new request waits
        rsp_ready = 1'b0;
        req_a     = 32'd10;
        req_b     = 32'd3;
        req_op    = OP_SUB;
        req_valid = 1'b1;
        step;
        req_a  = 32'd1;
        req_b  = 32'd1;
        req_op = OP_ADD;
        wait_cyc = 0;
        while (!rsp_valid && wait_cyc < 20) begin
            check("bp ready_low_wait", 32'(req_ready), 32'd0);
            step;
            wait_cyc++;
        end
        check("bp rsp_valid", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp result_held", rsp_result, 32'd7);
            check("bp op_held", 32'(rsp_op), 32'(OP_SUB));
            check("bp ready_low", 32'(req_ready), 32'd0);
            check("bp alu_a_held", alu_a, 32'd10);
            step;
        end
        rsp_ready = 1'b1;
        step;
        check("bp idle_ready", 32'(req_ready), 32'd1);
        check("bp rsp_valid_low", 32'(rsp_valid), 32'd0);
        check("bp alu_a_not_yet", alu_a, 32'd10);
        step;
        req_valid = 1'b0;
        check("bp new_accepted", alu_a, 32'd1);
        wait_cyc = 1;
        while (!rsp_valid && wait_cyc < 20) begin
            step;
            wait_cyc++;
        end
        check("bp new_latency", 32'(wait_cyc), 32'd2);
        check("bp new_result", rsp_result, 32'd2);
        step;

        // Reset mid-multiply when the wait counter reaches 10
        req_a     = 32'd5;
        req_b     = 32'd6;
        req_op    = OP_MUL;
        req_valid = 1'b1;
        step;
        req_valid = 1'b0;
        repeat (23) step;
        rst = 1'b1;
        #1;
        check("mrst busy", 32'(busy), 32'd0);
        check("mrst ready", 32'(req_ready), 32'd0);
        check("mrst mult_start", 32'(mult_start), 32'd0);
        check("mrst rsp_valid", 32'(rsp_valid), 32'd0);
        check("mrst alu_a", alu_a, 32'd0);
        check("mrst alu_op", 32'(alu_op), 32'd0);
        step;
        step;
        rst  = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            seen = seen | rsp_valid;
            step;
        end
        check("mrst no_rsp", 32'(seen), 32'd0);
        run_op("mul2", 32'd3, 32'd4, OP_MUL, 2 + MC, 32'd12);

        // Back-to-back and/slt, spacing of responses
        va[0] = 32'hF0F0_F0F0; vb[0] = 32'h0FF0_0FF0; vo[0] = OP_AND;
        va[1] = 32'hFFFF_FFFF; vb[1] = 32'd1;         vo[1] = OP_SLT;
        rr[0] = '0; rr[1] = '0; rc[0] = 0; rc[1] = 0;
        iss = 0;
        nr  = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid && nr < 2) begin
                rc[nr] = i;
                rr[nr] = rsp_result;
                nr++;
            end
            if (iss < 2) begin
                req_valid = 1'b1;
                req_a     = va[iss];
                req_b     = vb[iss];
                req_op    = vo[iss];
                if (req_ready) iss++;
            end else begin
                req_valid = 1'b0;
            end
            step;
        end
        req_valid = 1'b0;
        check("b2b rsp_count", 32'(nr), 32'd2);
        check("b2b and_result", rr[0], 32'h00F0_00F0);
        check("b2b slt_result", rr[1], 32'd1);
        check("b2b spacing", 32'(rc[1] - rc[0]), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
